// File: rtl/softmax_norm_seq.sv
// softmax_norm_seq: buffers one row of N non-negative exp() values, builds
// their saturating sum, then normalises each element through an external
// trial-division divider (hold-until-valid start protocol) and streams the
// quotients downstream with a valid/ready handshake.
// Optional feature: define SOFTMAX_NORM_DIV_TIMEOUT_EN to add a divider
// watchdog of DIV_TIMEOUT cycles in S_WAIT and the sticky O_ERR output.
module softmax_norm_seq #(
  parameter int unsigned D_W         = 16,
  parameter int unsigned N           = 8,
  parameter int unsigned IDX_W       = $clog2(N),
  parameter int unsigned DIV_TIMEOUT = 64
) (
  input  logic             I_CLK,
  input  logic             I_RST,
  input  logic             I_VLD,
  input  logic [D_W-1:0]   I_DATA,
  output logic             O_RDY,
  output logic             O_DIV_START,
  output logic [D_W-1:0]   O_DIVIDEND,
  output logic [D_W-1:0]   O_DIVISOR,
  input  logic [D_W-1:0]   I_QUOTIENT,
  input  logic             I_DIV_VLD,
  output logic             O_VLD,
  output logic [D_W-1:0]   O_DATA,
  output logic [IDX_W-1:0] O_IDX,
  output logic             O_LAST,
  input  logic             I_RDY
`ifdef SOFTMAX_NORM_DIV_TIMEOUT_EN
  ,
  output logic             O_ERR
`endif
);

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam logic [D_W-1:0]   SUM_MAX  = {1'b0, {(D_W-1){1'b1}}};
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [D_W-1:0]   sum_q, sum_d;
  logic [D_W-1:0]   elem_buf [N];
  logic             buf_we;

  logic [D_W-1:0]   in_val;
  logic [D_W:0]     sum_ext;
  logic [D_W-1:0]   sum_sat;

  logic             rdy_d, start_d, vld_d, last_d;
  logic [D_W-1:0]   dividend_d, divisor_d, data_d;
  logic [IDX_W-1:0] idx_d;

  // The input MSB is forced to zero; keep it visibly consumed.
  logic unused_data_msb;
  assign unused_data_msb = I_DATA[D_W-1];

`ifdef SOFTMAX_NORM_DIV_TIMEOUT_EN
  localparam int unsigned       TMO_W    = $clog2(DIV_TIMEOUT + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(DIV_TIMEOUT - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_d;
`else
  logic unused_cfg;
  assign unused_cfg = (DIV_TIMEOUT == 0);
`endif

  // Masked input value and saturating running sum (one extra bit of headroom).
  always_comb begin
    in_val  = {1'b0, I_DATA[D_W-2:0]};
    sum_ext = {1'b0, sum_q} + {1'b0, in_val};
    sum_sat = (sum_ext > {1'b0, SUM_MAX}) ? SUM_MAX : sum_ext[D_W-1:0];
  end

  // Next-state and next-output logic; every registered output holds by default.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    buf_we     = 1'b0;
    rdy_d      = O_RDY;
    start_d    = O_DIV_START;
    dividend_d = O_DIVIDEND;
    divisor_d  = O_DIVISOR;
    vld_d      = O_VLD;
    data_d     = O_DATA;
    idx_d      = O_IDX;
    last_d     = O_LAST;
`ifdef SOFTMAX_NORM_DIV_TIMEOUT_EN
    tmo_d      = tmo_q;
    err_d      = O_ERR;
`endif
    case (state_q)
      S_LOAD: begin
        if (I_VLD) begin
          buf_we = 1'b1;
          sum_d  = sum_sat;
          if (cnt_q == IDX_LAST) begin
            cnt_d = '0;
            rdy_d = 1'b0;
            if (sum_sat == '0) begin
              // Zero row: skip the divider, every quotient is zero.
              state_d = S_OUT;
              vld_d   = 1'b1;
              data_d  = '0;
              idx_d   = '0;
              last_d  = 1'b0;
            end else begin
              state_d = S_ISSUE;
            end
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end
      end
      S_ISSUE: begin
        dividend_d = elem_buf[cnt_q];
        divisor_d  = sum_q;
        start_d    = 1'b1;
        state_d    = S_WAIT;
`ifdef SOFTMAX_NORM_DIV_TIMEOUT_EN
        tmo_d      = '0;
`endif
      end
      S_WAIT: begin
        if (I_DIV_VLD) begin
          data_d  = I_QUOTIENT;
          start_d = 1'b0;
          state_d = S_OUT;
          vld_d   = 1'b1;
          idx_d   = cnt_q;
          last_d  = (cnt_q == IDX_LAST);
        end
`ifdef SOFTMAX_NORM_DIV_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          data_d  = '0;
          start_d = 1'b0;
          err_d   = 1'b1;
          state_d = S_OUT;
          vld_d   = 1'b1;
          idx_d   = cnt_q;
          last_d  = (cnt_q == IDX_LAST);
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end
      S_OUT: begin
        if (I_RDY) begin
          if (cnt_q == IDX_LAST) begin
            sum_d   = '0;
            cnt_d   = '0;
            state_d = S_LOAD;
            vld_d   = 1'b0;
            last_d  = 1'b0;
            rdy_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
            if (sum_q == '0) begin
              vld_d  = 1'b1;
              data_d = '0;
              idx_d  = cnt_q + IDX_W'(1);
              last_d = ((cnt_q + IDX_W'(1)) == IDX_LAST);
            end else begin
              vld_d   = 1'b0;
              state_d = S_ISSUE;
            end
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // State, counters and registered outputs with synchronous reset.
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state_q     <= S_LOAD;
      cnt_q       <= '0;
      sum_q       <= '0;
      O_RDY       <= 1'b1;
      O_DIV_START <= 1'b0;
      O_DIVIDEND  <= '0;
      O_DIVISOR   <= '0;
      O_VLD       <= 1'b0;
      O_DATA      <= '0;
      O_IDX       <= '0;
      O_LAST      <= 1'b0;
`ifdef SOFTMAX_NORM_DIV_TIMEOUT_EN
      tmo_q       <= '0;
      O_ERR       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      O_RDY       <= rdy_d;
      O_DIV_START <= start_d;
      O_DIVIDEND  <= dividend_d;
      O_DIVISOR   <= divisor_d;
      O_VLD       <= vld_d;
      O_DATA      <= data_d;
      O_IDX       <= idx_d;
      O_LAST      <= last_d;
`ifdef SOFTMAX_NORM_DIV_TIMEOUT_EN
      tmo_q       <= tmo_d;
      O_ERR       <= err_d;
`endif
    end
  end

  // Row buffer; contents are don't-care after reset.
  always_ff @(posedge I_CLK) begin
    if (buf_we) elem_buf[cnt_q] <= in_val;
  end

endmodule

// File: doc/softmax_norm_seq.md
Name: softmax_norm_seq

Overview:
- Softmax normalisation sequencer that sits directly upstream of the positive fixed-point trial-division divider.
- Buffers a row of N non-negative exp() values and accumulates their saturating sum.
- Feeds the divider one (exp value, sum) pair at a time using the divider's hold-until-valid start protocol.
- Streams the N quotients to the downstream attention stage with a valid/ready handshake.

Parameters:
- D_W, 16, data width of exp values, sum and quotient; MSB is always 0 (positive Q format).
- N, 8, elements per softmax row; must be >= 2.
- IDX_W, $clog2(N), width of element index.
- DIV_TIMEOUT, 64, watchdog limit in cycles; used only with the optional feature.

Ports:
- I_CLK in 1 clock.
- I_RST in 1 reset; synchronous, active-high.
- I_VLD in 1 input element valid.
- I_DATA in D_W input exp value; bit D_W-1 is ignored and treated as 0.
- O_RDY out 1 ready to accept an input element.
- O_DIV_START out 1 divider start; held high for the whole division.
- O_DIVIDEND out D_W operand to the divider: buffered exp value.
- O_DIVISOR out D_W operand to the divider: row sum.
- I_QUOTIENT in D_W divider result.
- I_DIV_VLD in 1 divider result valid (single-cycle pulse).
- O_VLD out 1 output element valid.
- O_DATA out D_W normalised value.
- O_IDX out IDX_W index of the element within the row.
- O_LAST out 1 high with the last element of the row (O_IDX == N-1).
- I_RDY in 1 downstream ready.

Behaviour:
- Reset (I_RST high at a clock edge, regardless of state, including mid-division): state = S_LOAD; counters and sum cleared; O_RDY=1; O_DIV_START=0; O_VLD=0; O_LAST=0; O_DATA=0; O_IDX=0; O_DIVIDEND=0; O_DIVISOR=0. Buffer contents are don't-care.
- Reset mid-division: dropping O_DIV_START returns the divider to idle; the sequencer never consumes a stale I_DIV_VLD after reset.
- All outputs are registered.
- S_LOAD:
  - O_RDY=1. On I_VLD, store {0, I_DATA[D_W-2:0]} into buf[cnt].
  - sum <= min(sum + value, 2^(D_W-1)-1); the addition uses a D_W+1 bit intermediate.
  - On the N-th accepted element: O_RDY drops in the next cycle and cnt=0.
  - If the final sum == 0, go to S_OUT with O_DATA=0 (zero-row bypass; the divider is never started).
  - Otherwise go to S_ISSUE.
- S_ISSUE:
  - O_DIVIDEND=buf[cnt], O_DIVISOR=sum, O_DIV_START=1, then go to S_WAIT.
  - Operands and start stay stable until I_DIV_VLD.
- S_WAIT:
  - Hold operands and start.
  - On I_DIV_VLD: O_DATA <= I_QUOTIENT, O_DIV_START <= 0, go to S_OUT.
- S_OUT:
  - O_VLD=1, O_IDX=cnt, O_LAST=(cnt==N-1).
  - O_DATA, O_IDX and O_LAST stay stable while I_RDY=0.
  - On O_VLD && I_RDY: if not last, cnt++ and go to S_ISSUE (or stay in S_OUT with O_DATA=0 in zero-row bypass). If last, clear sum and cnt, go to S_LOAD.
- Divider start gap: O_DIV_START is low for at least one cycle between consecutive divisions, because S_OUT always lasts at least one cycle. This guarantees the divider passes through idle before restarting.
- No input is accepted outside S_LOAD; a new row's loading never overlaps the current row's output.
- Throughput: roughly N*(divider latency + 2) cycles per row plus N load cycles.
- I_DIV_VLD seen outside S_WAIT is ignored.

Optional Feature:
- Macro SOFTMAX_NORM_DIV_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in S_WAIT.
  - If DIV_TIMEOUT cycles elapse without I_DIV_VLD: O_DIV_START <= 0, O_DATA <= 0, go to S_OUT.
  - A sticky extra output O_ERR (1 bit) sets to 1. It clears only on I_RST.
- Undefined: no counter and no O_ERR port; S_WAIT waits for I_DIV_VLD indefinitely.

Test Plan:
- Basic row (N=4, D_W=16): inputs 0x2000,0x2000,0x2000,0x2000 -> divisor 0x8000 saturates to 0x7FFF; four divisions issued with O_DIVIDEND=0x2000; outputs O_IDX 0..3; O_LAST only with idx 3; O_DATA equals the model quotient.
- Start protocol: check O_DIV_START is held with stable operands until I_DIV_VLD, then low for >=1 cycle before the next start; with a behavioural divider model of latency 30, each element takes >=32 cycles.
- Zero row: four 0x0000 inputs -> O_DIV_START never asserts; four outputs with O_DATA=0.
- Backpressure: I_RDY low for 5 cycles on idx 2 -> O_VLD, O_DATA and O_IDX stay stable; no new division starts until the handshake completes.
- Reset mid-operation: assert I_RST during S_WAIT of idx 1 -> next cycle O_DIV_START=0, O_VLD=0, O_RDY=1; a fresh row of 0x1000 x4 then normalises correctly.
- Timeout (macro defined, DIV_TIMEOUT=64): divider model never pulses I_DIV_VLD -> after 64 cycles O_DATA=0 with O_VLD=1 and O_ERR=1; O_ERR stays 1 after the row completes.
